// File: rtl/btn_dfu_wb.sv
// Button front-end: pad synchronisers, debouncers, a Wishbone status register with
// sticky press events, and boot-button handling for reset / warm-boot requests.
module btn_dfu_wb #(
   parameter int         NUM_BTN        = 2,
   parameter int         DEBOUNCE_WIDTH = 16,
   parameter int         TIMER_WIDTH    = 24,
   parameter logic [1:0] DFU_SEL        = 2'b01
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn,
   input  logic               btn_pad,
   input  logic               wb_cyc,
   input  logic               wb_we,
   output logic [31:0]        wb_rdata,
   output logic               wb_ack,
   input  logic               boot_now,
   input  logic [1:0]         boot_sel,
   output logic               btn_val,
   output logic               rst_req,
   output logic               boot_req,
   output logic [1:0]         boot_sel_o
);

   // PCB buttons occupy bits [NUM_BTN-1:0]; the boot button rides along as bit NUM_BTN
   // so all pads share one synchroniser/debouncer description.
   localparam int NI = NUM_BTN + 1;

   localparam logic [DEBOUNCE_WIDTH-1:0] DB_ONE  = DEBOUNCE_WIDTH'(1);
   localparam logic [DEBOUNCE_WIDTH-1:0] DB_MAX  = '1;
   localparam logic [DEBOUNCE_WIDTH-1:0] DB_LAST = DB_MAX - DB_ONE;
   localparam logic [TIMER_WIDTH-1:0]    TMR_ONE = TIMER_WIDTH'(1);
   localparam logic [TIMER_WIDTH-1:0]    TMR_MAX = '1;

   logic [NI-1:0]                     sync1_q, sync2_q;
   logic [NI-1:0]                     raw_pressed;
   logic [NI-1:0][DEBOUNCE_WIDTH-1:0] db_cnt_q, db_cnt_d;
   logic [NI-1:0]                     db_state_q, db_state_d;
   logic [NUM_BTN-1:0]                evt_q, evt_d;
   logic                              wb_ack_q, wb_ack_d;
   logic [31:0]                       wb_rdata_q, wb_rdata_d;
   logic [31:0]                       reg_val;
   logic                              rd_capture;
   logic [TIMER_WIDTH-1:0]            timer_q, timer_d;
   logic                              timer_sat;
   logic                              rst_req_q, rst_req_d;
   logic                              boot_req_q, boot_req_d;
   logic [1:0]                        boot_sel_q, boot_sel_d;

   // Pads are active-low; after the two-flop synchroniser a 1 means pressed.
   assign raw_pressed = ~sync2_q;

   // Debounce: the state follows the pad only after 2^DEBOUNCE_WIDTH-1 consecutive
   // disagreeing cycles; the counter flips state on the cycle it would hit all-ones.
   always_comb begin
      db_state_d = db_state_q;
      db_cnt_d   = '0;
      for (int i = 0; i < NI; i++) begin
         if (raw_pressed[i] != db_state_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               db_state_d[i] = raw_pressed[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
            end
         end
      end
   end

   assign reg_val    = 32'(db_state_q[NUM_BTN-1:0]) | (32'(evt_q) << 8);
   assign rd_capture = wb_cyc & ~wb_we & ~wb_ack_q;

   // Wishbone handshake and sticky events; a press arriving in the read-capture cycle
   // is OR-ed in after the clear so it is never lost.
   always_comb begin
      wb_ack_d   = wb_cyc & ~wb_ack_q;
      wb_rdata_d = rd_capture ? reg_val : 32'd0;
      evt_d      = rd_capture ? '0 : evt_q;
      evt_d      = evt_d | (db_state_d[NUM_BTN-1:0] & ~db_state_q[NUM_BTN-1:0]);
   end

   assign timer_sat = (timer_q == TMR_MAX);

   // Boot button: long-press timer, short-press reset pulse, and the sticky warm-boot
   // request where software takes priority over a long press landing the same cycle.
   always_comb begin
      if (!db_state_q[NUM_BTN]) begin
         timer_d = '0;
      end else if (!timer_sat) begin
         timer_d = timer_q + TMR_ONE;
      end else begin
         timer_d = timer_q;
      end
      rst_req_d  = db_state_q[NUM_BTN] & ~db_state_d[NUM_BTN] & ~timer_sat;
      boot_req_d = boot_req_q;
      boot_sel_d = boot_sel_q;
      if (!boot_req_q) begin
         if (boot_now) begin
            boot_req_d = 1'b1;
            boot_sel_d = boot_sel;
         end else if (timer_sat) begin
            boot_req_d = 1'b1;
            boot_sel_d = DFU_SEL;
         end
      end
   end

   // All state registers; synchronisers reset to the idle (released, high) pad level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '1;
         sync2_q    <= '1;
         db_cnt_q   <= '0;
         db_state_q <= '0;
         evt_q      <= '0;
         wb_ack_q   <= 1'b0;
         wb_rdata_q <= 32'd0;
         timer_q    <= '0;
         rst_req_q  <= 1'b0;
         boot_req_q <= 1'b0;
         boot_sel_q <= 2'b00;
      end else begin
         sync1_q    <= {btn_pad, btn};
         sync2_q    <= sync1_q;
         db_cnt_q   <= db_cnt_d;
         db_state_q <= db_state_d;
         evt_q      <= evt_d;
         wb_ack_q   <= wb_ack_d;
         wb_rdata_q <= wb_rdata_d;
         timer_q    <= timer_d;
         rst_req_q  <= rst_req_d;
         boot_req_q <= boot_req_d;
         boot_sel_q <= boot_sel_d;
      end
   end

   assign wb_ack     = wb_ack_q;
   assign wb_rdata   = wb_rdata_q;
   assign btn_val    = db_state_q[NUM_BTN];
   assign rst_req    = rst_req_q;
   assign boot_req   = boot_req_q;
   assign boot_sel_o = boot_sel_q;

endmodule

// File: tb/tb_btn_dfu_wb.sv
// Directed bench for btn_dfu_wb with short debounce/timer widths.
module tb_btn_dfu_wb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  btn;
   logic        btn_pad;
   logic        wb_cyc;
   logic        wb_we;
   logic [31:0] wb_rdata;
   logic        wb_ack;
   logic        boot_now;
   logic [1:0]  boot_sel;
   logic        btn_val;
   logic        rst_req;
   logic        boot_req;
   logic [1:0]  boot_sel_o;

   int n_vec = 0;
   int n_err = 0;
   int rst_hits;
   logic saw_val;

   btn_dfu_wb #(
      .NUM_BTN(2),
      .DEBOUNCE_WIDTH(2),
      .TIMER_WIDTH(4),
      .DFU_SEL(2'b01)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn(btn),
      .btn_pad(btn_pad),
      .wb_cyc(wb_cyc),
      .wb_we(wb_we),
      .wb_rdata(wb_rdata),
      .wb_ack(wb_ack),
      .boot_now(boot_now),
      .boot_sel(boot_sel),
      .btn_val(btn_val),
      .rst_req(rst_req),
      .boot_req(boot_req),
      .boot_sel_o(boot_sel_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One bus cycle: ack must be low before, high for exactly one cycle, then low again.
   task automatic wb_access(input string tag, input logic we, input logic [31:0] exp);
      check({tag, "_ack_pre"}, 32'(wb_ack), 32'd0);
      wb_cyc = 1'b1;
      wb_we  = we;
      tick(1);
      check({tag, "_ack"}, 32'(wb_ack), 32'd1);
      check({tag, "_data"}, wb_rdata, exp);
      wb_cyc = 1'b0;
      wb_we  = 1'b0;
      tick(1);
      check({tag, "_ack_post"}, 32'(wb_ack), 32'd0);
   endtask

   // Watch rst_req/btn_val for n cycles, accumulating pulse cycles and whether btn_val rose.
   task automatic watch(input int n);
      repeat (n) begin
         tick(1);
         if (rst_req === 1'b1) rst_hits++;
         if (btn_val === 1'b1) saw_val = 1'b1;
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      btn      = 2'b11;
      btn_pad  = 1'b1;
      wb_cyc   = 1'b0;
      wb_we    = 1'b0;
      boot_now = 1'b0;
      boot_sel = 2'b00;
      tick(3);

      // Reset state
      check("rst_rdata", wb_rdata, 32'd0);
      check("rst_ack", 32'(wb_ack), 32'd0);
      check("rst_btn_val", 32'(btn_val), 32'd0);
      check("rst_rst_req", 32'(rst_req), 32'd0);
      check("rst_boot_req", 32'(boot_req), 32'd0);
      check("rst_boot_sel", 32'(boot_sel_o), 32'd0);
      rst_n = 1'b1;
      tick(2);
      wb_access("rd_idle", 1'b0, 32'h0000_0000);

      // Held press on btn[0]: state and event, then event cleared by the read
      btn = 2'b10;
      tick(8);
      wb_access("rd_press0", 1'b0, 32'h0000_0101);
      wb_access("rd_press0_again", 1'b0, 32'h0000_0001);
      btn = 2'b11;
      tick(8);
      wb_access("rd_release0", 1'b0, 32'h0000_0000);

      // Two-cycle glitch on btn[1] is rejected
      btn = 2'b01;
      tick(2);
      btn = 2'b11;
      tick(10);
      wb_access("rd_glitch2", 1'b0, 32'h0000_0000);

      // Three-cycle pulse is just long enough: event latched, state back to released.
      // A write in between acks with zero data and leaves the event alone.
      btn = 2'b01;
      tick(3);
      btn = 2'b11;
      tick(10);
      wb_access("wr_nochange", 1'b1, 32'h0000_0000);
      wb_access("rd_pulse3", 1'b0, 32'h0000_0200);
      wb_access("rd_pulse3_again", 1'b0, 32'h0000_0000);

      // Short boot-button press -> single rst_req cycle, no boot request
      rst_hits = 0;
      saw_val  = 1'b0;
      btn_pad  = 1'b0;
      watch(8);
      btn_pad  = 1'b1;
      watch(25);
      check("short_btn_val_seen", 32'(saw_val), 32'd1);
      check("short_rst_pulses", 32'(rst_hits), 32'd1);
      check("short_boot_req", 32'(boot_req), 32'd0);
      check("short_btn_val_end", 32'(btn_val), 32'd0);

      // Long press -> DFU boot request; release gives no rst_req
      btn_pad = 1'b0;
      tick(40);
      check("long_btn_val", 32'(btn_val), 32'd1);
      check("long_boot_req", 32'(boot_req), 32'd1);
      check("long_boot_sel", 32'(boot_sel_o), 32'd1);
      rst_hits = 0;
      saw_val  = 1'b0;
      btn_pad  = 1'b1;
      watch(20);
      check("long_rel_rst_pulses", 32'(rst_hits), 32'd0);
      check("long_rel_boot_req", 32'(boot_req), 32'd1);
      check("long_rel_btn_val", 32'(btn_val), 32'd0);

      // Request is frozen: software cannot change the selected image afterwards
      boot_now = 1'b1;
      boot_sel = 2'b10;
      tick(1);
      boot_now = 1'b0;
      tick(1);
      check("frozen_boot_req", 32'(boot_req), 32'd1);
      check("frozen_boot_sel", 32'(boot_sel_o), 32'd1);

      // Reset mid-operation drops a pending ack and clears the boot request
      wb_cyc = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_ack_before", 32'(wb_ack), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_ack", 32'(wb_ack), 32'd0);
      check("midrst_boot_req", 32'(boot_req), 32'd0);
      check("midrst_boot_sel", 32'(boot_sel_o), 32'd0);
      wb_cyc = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // Software warm-boot request, then a long press is ignored
      boot_now = 1'b1;
      boot_sel = 2'b10;
      tick(1);
      check("sw_boot_req", 32'(boot_req), 32'd1);
      check("sw_boot_sel", 32'(boot_sel_o), 32'd2);
      boot_now = 1'b0;
      boot_sel = 2'b00;
      btn_pad  = 1'b0;
      tick(40);
      check("sw_long_btn_val", 32'(btn_val), 32'd1);
      check("sw_long_boot_req", 32'(boot_req), 32'd1);
      check("sw_long_boot_sel", 32'(boot_sel_o), 32'd2);
      btn_pad = 1'b1;
      tick(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
